// File: rtl/outlier_pkg.sv
// Shared constants, lane-index type and FSM encoding for the outlier index generator.
// Optional perf counters in outlier_index_gen are enabled by OUTIDX_PERF_CNT_EN.
package outlier_pkg;

  localparam int unsigned DIMM_DEF   = 64;
  localparam int unsigned NUM_LR_DEF = 4;
  localparam int unsigned SCAN_W_DEF = 8;
  localparam int unsigned IDX_W_DEF  = $clog2(DIMM_DEF);

  typedef logic [IDX_W_DEF-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

endpackage

// File: rtl/outlier_index_gen_chunk_prefix_cnt.sv
// Per-bit exclusive prefix popcount of one scan slice, plus the slice popcount.
module chunk_prefix_cnt #(
  parameter int unsigned SCAN_W = 8,
  parameter int unsigned PreW   = $clog2(SCAN_W + 1)
) (
  input  logic [SCAN_W-1:0]           bits,
  output logic [SCAN_W-1:0][PreW-1:0] pre,
  output logic [PreW-1:0]             total
);

  logic [PreW-1:0] acc;

  always_comb begin
    acc = '0;
    pre = '0;
    for (int k = 0; k < int'(SCAN_W); k++) begin
      pre[k] = acc;
      acc    = acc + PreW'(bits[k]);
    end
    total = acc;
  end

endmodule

// File: rtl/outlier_index_gen.sv
// Scans an overflow vector SCAN_W lanes per cycle and emits a lane permutation with
// outliers packed low and inliers packed high. OUTIDX_PERF_CNT_EN adds perf counters.
module outlier_index_gen
  import outlier_pkg::*;
#(
  parameter int unsigned DIMM       = DIMM_DEF,
  parameter int unsigned NUM_LR     = NUM_LR_DEF,
  parameter int unsigned SCAN_W     = SCAN_W_DEF,
  parameter int unsigned IndexWidth = $clog2(DIMM)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DIMM-1:0]                  overflow,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DIMM-1:0][IndexWidth-1:0]  index,
  output logic [$clog2(DIMM+1)-1:0]        outlier_cnt,
  output logic                             excess
`ifdef OUTIDX_PERF_CNT_EN
  ,
  output logic [31:0]                      perf_vec_cnt,
  output logic [31:0]                      perf_excess_cnt
`endif
);

  localparam int unsigned CntW      = $clog2(DIMM + 1);
  localparam int unsigned PreW      = $clog2(SCAN_W + 1);
  localparam int unsigned NumChunks = DIMM / SCAN_W;
  localparam int unsigned ChunkW    = (NumChunks > 1) ? $clog2(NumChunks) : 1;

  state_t                   state;
  logic [DIMM-1:0]          ovf_q;
  logic [CntW-1:0]          lo_ptr;
  logic [IndexWidth-1:0]    hi_ptr;
  logic [ChunkW-1:0]        chunk;

  logic [SCAN_W-1:0]                  slice;
  logic [SCAN_W-1:0][PreW-1:0]        pre;
  logic [PreW-1:0]                    pop;
  logic [SCAN_W-1:0][IndexWidth-1:0]  wr_slot;
  logic [SCAN_W-1:0][IndexWidth-1:0]  wr_lane;
  logic [CntW-1:0]                    cnt_next;
  logic                               last_chunk;

  assign slice      = SCAN_W'(ovf_q >> (32'(chunk) * SCAN_W));
  assign cnt_next   = lo_ptr + CntW'(pop);
  assign last_chunk = (chunk == ChunkW'(NumChunks - 1));
  // lo_ptr counts every outlier seen so far, so it doubles as the reported count
  assign outlier_cnt = lo_ptr;

  chunk_prefix_cnt #(
    .SCAN_W (SCAN_W),
    .PreW   (PreW)
  ) u_prefix (
    .bits  (slice),
    .pre   (pre),
    .total (pop)
  );

  // Write slot per lane: outliers climb from lo_ptr, inliers descend from hi_ptr
  always_comb begin
    wr_slot = '0;
    wr_lane = '0;
    for (int k = 0; k < int'(SCAN_W); k++) begin
      wr_lane[k] = IndexWidth'(32'(chunk) * SCAN_W + 32'(k));
      if (slice[k]) begin
        wr_slot[k] = IndexWidth'(lo_ptr) + IndexWidth'(pre[k]);
      end else begin
        wr_slot[k] = hi_ptr - (IndexWidth'(k) - IndexWidth'(pre[k]));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      index     <= '0;
      excess    <= 1'b0;
      ovf_q     <= '0;
      lo_ptr    <= '0;
      hi_ptr    <= '0;
      chunk     <= '0;
`ifdef OUTIDX_PERF_CNT_EN
      perf_vec_cnt    <= '0;
      perf_excess_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ovf_q    <= overflow;
            lo_ptr   <= '0;
            hi_ptr   <= IndexWidth'(DIMM - 1);
            chunk    <= '0;
            excess   <= 1'b0;
            in_ready <= 1'b0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          for (int k = 0; k < int'(SCAN_W); k++) begin
            index[wr_slot[k]] <= wr_lane[k];
          end
          lo_ptr <= cnt_next;
          hi_ptr <= hi_ptr - (IndexWidth'(SCAN_W) - IndexWidth'(pop));
          chunk  <= chunk + ChunkW'(1);
          if (last_chunk) begin
            out_valid <= 1'b1;
            excess    <= (32'(cnt_next) > NUM_LR);
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
`ifdef OUTIDX_PERF_CNT_EN
            if (perf_vec_cnt != '1) perf_vec_cnt <= perf_vec_cnt + 32'd1;
            if (excess && perf_excess_cnt != '1) perf_excess_cnt <= perf_excess_cnt + 32'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/outlier_index_gen.md
Name: outlier_index_gen

Overview:
- Producer of the per-lane index permutation consumed by the inlier segment datapath.
- Takes the DIMM-bit fp16-to-int3 overflow vector and scans it SCAN_W bits per cycle.
- Emits a DIMM-entry index array: outlier lanes in the low slots (0 up to NUM_LR-1 and beyond), inlier lanes in the high slots.
- Output is always a full permutation of 0..DIMM-1, presented on a valid/ready handshake.

Parameters:
- DIMM, 64, number of lanes (PEs); power of 2.
- NUM_LR, 4, number of outlier slots reserved by the consumer.
- SCAN_W, 8, overflow bits examined per cycle; power of 2; divides DIMM.
- IndexWidth, $clog2(DIMM), width of one lane index.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  overflow vector valid.
- in_ready  out  1  block can accept a vector.
- overflow  in  DIMM  bit i = 1 means lane i is an outlier.
- out_valid  out  1  index array valid.
- out_ready  in  1  consumer accepts the array.
- index  out  DIMM x IndexWidth  lane permutation; slot s holds a lane number.
- outlier_cnt  out  $clog2(DIMM+1)  number of set overflow bits.
- excess  out  1  outlier_cnt > NUM_LR.

Behaviour:
- Reset values: in_ready=1, out_valid=0, index all 0, outlier_cnt=0, excess=0, FSM=IDLE.
- States:
  - IDLE: in_ready=1. On in_valid, capture overflow into an internal copy, clear lo_ptr=0, hi_ptr=DIMM-1, chunk=0, then go to SCAN.
  - SCAN: in_ready=0. Each cycle processes bits [chunk*SCAN_W +: SCAN_W] in ascending lane order.
    - Outlier lane j: index[lo_ptr + (outliers before j in this chunk)] = j.
    - Inlier lane j: index[hi_ptr - (inliers before j in this chunk)] = j.
    - lo_ptr increases by the chunk popcount; hi_ptr decreases by SCAN_W minus the popcount.
    - After the last chunk (DIMM/SCAN_W cycles), go to DONE.
  - DONE: out_valid=1. index, outlier_cnt and excess are stable until out_valid & out_ready; then go to IDLE.
- Latency: out_valid is first high DIMM/SCAN_W cycles after the accepting edge (8 with defaults).
- Throughput: no overlap; in_ready rises the cycle after the output handshake.
- Ordering guarantees:
  - Outliers occupy slots 0..cnt-1 in ascending lane order.
  - Inliers occupy slots DIMM-1 down to cnt, so the first inlier lane sits in slot DIMM-1.
  - lo_ptr + (DIMM-1-hi_ptr) = lanes scanned, so every slot is written exactly once.
- Fewer than NUM_LR outliers: slots cnt..NUM_LR-1 hold inlier lanes (the last-scanned inliers). This is legal; the consumer treats them as outlier slots.
- More than NUM_LR outliers: the extra outliers occupy slots NUM_LR..cnt-1 and excess=1. The array is still a permutation; the upstream controller handles the excess.
- All-outlier vector: cnt=DIMM, index[s]=s, excess=1 (when NUM_LR < DIMM).
- in_valid while not IDLE: ignored and not latched.
- out_ready while not DONE: ignored.
- rst mid-SCAN or mid-DONE: immediate return to reset values; the partial result is discarded.

Optional Feature:
- OUTIDX_PERF_CNT_EN defined: adds outputs perf_vec_cnt[31:0] and perf_excess_cnt[31:0].
  - perf_vec_cnt increments on each output handshake.
  - perf_excess_cnt increments on each output handshake with excess=1.
  - Both saturate at 2^32-1 and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package outlier_pkg:
  - Constants DIMM_DEF=64, NUM_LR_DEF=4.
  - typedef idx_t (logic [IndexWidth-1:0]).
  - FSM enum state_t {IDLE, SCAN, DONE}.
- Sub-module chunk_prefix_cnt: combinational per-bit exclusive prefix popcount of a SCAN_W-bit slice plus the total popcount. It is instantiated once and drives both write-address calculations.

Test Plan:
- overflow=0, defaults: out_valid high 8 cycles after accept; index[63]=0, index[62]=1, …, index[0]=63; cnt=0; excess=0.
- overflow bits {5,17,40,63}: index[0..3]=5,17,40,63; index[63]=0, index[4]=62; cnt=4; excess=0.
- overflow bits {1..6}: index[0..5]=1..6; index[63]=0; cnt=6; excess=1. A scoreboard confirms the array is a permutation of 0..63.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE → out_valid, index and cnt held, in_ready=0, a new in_valid is ignored. out_ready=1 → in_ready=1 on the next cycle.
- Assert rst at scan cycle 3 → out_valid=0, in_ready=1, index all 0 immediately. A subsequent vector with bit 10 set yields index[0]=10.
- With OUTIDX_PERF_CNT_EN: three vectors, one with 5 outliers → perf_vec_cnt=3, perf_excess_cnt=1.
